uart_byte_tx: RTL and testbench
===============================

Name: uart_byte_tx

Overview:
- Downstream consumer of the byte-stream serializer output.
- Takes 8-bit bytes over a valid/ready handshake and transmits each as an 8N1 UART frame on the board TX pin, LSB first.
- Carries in_last so frame boundaries can be marked on the serial line (optional feature).
- Sits between the array serializer and the Basys USB-UART bridge.

Parameters:
- CLOCK_FREQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate in baud.
- Derived localparam CLKS_PER_BIT = (CLOCK_FREQ + BAUD_RATE/2) / BAUD_RATE (rounded). Must be >= 2.
- Derived bit-timer counter width = $clog2(CLKS_PER_BIT).

Ports:
- clock     input   1  system clock; all logic on the rising edge.
- reset     input   1  synchronous, active-high reset.
- in_data   input   8  byte to transmit.
- in_valid  input   1  in_data/in_last valid.
- in_ready  output  1  block can accept a byte this cycle.
- in_last   input   1  byte is the final byte of a stream/array.
- tx        output  1  serial line, idle high; registered output.
- busy      output  1  high whenever state != IDLE.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset values: state=IDLE, tx=1, in_ready=1, busy=0, bit timer=0, bit index=0, shift register=0, last flag=0.
- Reset mid-frame abandons the frame; tx is 1 from the next edge onward.
- States: IDLE, START, DATA, STOP, plus NL_START when the macro is enabled.
- in_ready = (state == IDLE), combinational from state. No skid buffer.
- Accept on in_valid && in_ready: latch in_data into the shift register and in_last into the last flag. Go to START on the next edge.
- in_data is ignored when not accepted.
- START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA: tx = shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After bit 7, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Bit timer counts 0..CLKS_PER_BIT-1 and clears on every state change.
- tx changes only on bit boundaries. The first start-bit cycle is the cycle after the accept edge.
- in_ready is low for exactly 10*CLKS_PER_BIT cycles per frame.
- Back-to-back: a byte offered continuously is accepted in the first IDLE cycle. The line stays high 1 extra cycle between frames (stop effectively CLKS_PER_BIT+1 cycles).
- in_valid deasserting while busy has no effect. The held byte is still transmitted in full.
- No other buffering; throughput is bounded by the baud rate.

Optional Feature:
- Macro: UART_TX_LAST_NEWLINE_EN.
- Defined: when a frame whose latched last flag = 1 finishes STOP, go directly to NL_START (no IDLE cycle). Transmit a full 0x0A frame, then IDLE.
  - in_ready stays low throughout: 20*CLKS_PER_BIT cycles total for the last byte.
  - busy stays high.
  - The last flag clears when the newline frame starts.
- Undefined: in_last is accepted but ignored; no NL_START state is synthesized.

Test Plan:
- Bench uses CLOCK_FREQ=1000, BAUD_RATE=100, so CLKS_PER_BIT=10.
- Reset, then idle 50 cycles -> tx=1, in_ready=1, busy=0 throughout.
- Send 0x55 with in_last=0 -> tx=0 for cycles 1-10 after accept. Data bits 1,0,1,0,1,0,1,0 at 10 cycles each. Stop high 10 cycles. in_ready returns high at cycle 101.
- Hold in_valid high with 0xA3 then 0x0F -> bench UART receiver decodes 0xA3, 0x0F. Start of the second frame is exactly 101 cycles after the first start. No byte is dropped or duplicated.
- Assert reset during the data bit 3 of 0xFF -> tx=1 and in_ready=1 on the next cycle. A following 0x01 is decoded correctly.
- Drop in_valid one cycle after accepting 0x3C and change in_data to 0x00 -> 0x3C is still transmitted intact.
- With UART_TX_LAST_NEWLINE_EN, send 0x41 with in_last=1 -> decoded 0x41 then 0x0A. in_ready low 200 cycles. No high gap beyond the stop bit between the two frames.
- Without the macro, the same stimulus -> only 0x41 is decoded.

Source files
------------

// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter with a valid/ready byte input, LSB first, idle-high registered tx.
// Optional: define UART_TX_LAST_NEWLINE_EN to append a 0x0A frame after any byte flagged in_last.
module uart_byte_tx #(
  parameter int CLOCK_FREQ = 100000000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_last,
  output logic       tx,
  output logic       busy
);

  // Rounded divide; the bit timer needs at least two clocks per bit.
  localparam int CLKS_PER_BIT = (CLOCK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int TIMER_W      = $clog2(CLKS_PER_BIT);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_TX_LAST_NEWLINE_EN
    , NL_START
`endif
  } state_t;

  state_t             state, state_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic [2:0]         bit_index, index_next;
  logic [7:0]         shift_reg, shift_next;
  logic               last_flag, last_next;
  logic               tx_next;
  logic               bit_done;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign bit_done = (timer == TIMER_MAX);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    timer_next = timer;
    index_next = bit_index;
    shift_next = shift_reg;
    last_next  = last_flag;

    if (state != IDLE) timer_next = bit_done ? '0 : timer + 1'b1;

    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = START;
          shift_next = in_data;
          last_next  = in_last;
          timer_next = '0;
        end
      end
      START: begin
        if (bit_done) begin
          state_next = DATA;
          index_next = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_index == 3'd7) state_next = STOP;
          else                   index_next = bit_index + 3'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
`ifdef UART_TX_LAST_NEWLINE_EN
          if (last_flag) begin
            state_next = NL_START;
            shift_next = 8'h0A;
            last_next  = 1'b0;
          end else begin
            state_next = IDLE;
          end
`else
          state_next = IDLE;
`endif
        end
      end
`ifdef UART_TX_LAST_NEWLINE_EN
      NL_START: begin
        if (bit_done) begin
          state_next = DATA;
          index_next = '0;
        end
      end
`endif
      default: state_next = IDLE;
    endcase

    // tx is registered from the upcoming state so it moves exactly on bit boundaries.
    case (state_next)
      START:   tx_next = 1'b0;
`ifdef UART_TX_LAST_NEWLINE_EN
      NL_START: tx_next = 1'b0;
`endif
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      bit_index <= '0;
      shift_reg <= '0;
      last_flag <= 1'b0;
      tx        <= 1'b1;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      bit_index <= index_next;
      shift_reg <= shift_next;
      last_flag <= last_next;
      tx        <= tx_next;
    end
  end

`ifndef UART_TX_LAST_NEWLINE_EN
  // in_last is still latched for interface compatibility but drives nothing in this build.
  logic unused_last;
  assign unused_last = last_flag;
`endif

endmodule

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench for uart_byte_tx: frame-level line model, independent UART receiver, random bytes.
module tb_uart_byte_tx;

  localparam int CPB   = 10;
  localparam int FRAME = 10 * CPB;
`ifdef UART_TX_LAST_NEWLINE_EN
  localparam bit NL_EN = 1'b1;
`else
  localparam bit NL_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       in_last;
  logic       tx;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int exp_q[$];
  int rx_q[$];
  int rx_start_q[$];
  int last_start = 0;

  uart_byte_tx #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .tx       (tx),
    .busy     (busy)
  );

  initial forever #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Independent receiver: detects a falling edge, samples mid-bit, flags framing errors with bit 8.
  initial begin : rx_proc
    logic [7:0] rb;
    int st;
    forever begin
      @(negedge clock);
      if (tx === 1'b0) begin
        st = cyc;
        repeat (CPB / 2 - 1) @(negedge clock);
        if (tx === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clock);
            rb[i] = tx;
          end
          repeat (CPB) @(negedge clock);
          rx_q.push_back(int'(rb) | ((tx === 1'b1) ? 0 : 256));
          rx_start_q.push_back(st);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Line level k cycles (1-based) after a frame's accept edge: start, 8 data bits LSB first, stop.
  function automatic logic exp_line(input logic [7:0] b, input int k);
    int bit_no;
    bit_no = (k - 1) / CPB;
    if (bit_no == 0) return 1'b0;
    if (bit_no <= 8) return b[bit_no-1];
    return 1'b1;
  endfunction

  // Offer b, accept it, then check every cycle of the frame(s); in_valid stays high for hold cycles.
  task automatic run_frame(input logic [7:0] b, input logic last, input int hold,
                           input logic [7:0] next_data);
    int len;
    int kk;
    logic [7:0] cur;
    check("ready_before_accept", in_ready, 1);
    in_data  = b;
    in_last  = last;
    in_valid = 1'b1;
    tick();
    in_data = next_data;
    in_last = 1'b0;
    if (hold == 0) in_valid = 1'b0;
    len = (last && NL_EN) ? 2 * FRAME : FRAME;
    for (int k = 1; k <= len; k++) begin
      if (k > 1) tick();
      if (k == hold + 1) in_valid = 1'b0;
      cur = (k > FRAME) ? 8'h0A : b;
      kk  = (k > FRAME) ? k - FRAME : k;
      check("frame_tx", tx, exp_line(cur, kk));
      check("frame_in_ready_low", in_ready, 0);
      check("frame_busy_high", busy, 1);
    end
    exp_q.push_back(int'(b));
    if (last && NL_EN) exp_q.push_back(32'h0A);
  endtask

  task automatic check_idle_next();
    tick();
    check("idle_in_ready", in_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_tx", tx, 1);
  endtask

  task automatic check_rx();
    check("rx_count", rx_q.size(), exp_q.size());
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      check("rx_byte", rx_q.pop_front(), exp_q.pop_front());
      last_start = rx_start_q.pop_front();
    end
    exp_q.delete();
    rx_q.delete();
    rx_start_q.delete();
  endtask

  initial begin
    int t1;
    logic [7:0] rb;
    logic rl;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    repeat (3) tick();
    check("rst_tx", tx, 1);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    // Idle line with random data present but no valid.
    for (int i = 0; i < 50; i++) begin
      in_data = 8'($urandom);
      tick();
      check("idle50_tx", tx, 1);
      check("idle50_in_ready", in_ready, 1);
      check("idle50_busy", busy, 0);
    end

    // Single 0x55 frame, ready returns at cycle 101.
    run_frame(8'h55, 1'b0, 0, 8'hFF);
    check_rx();
    check_idle_next();

    // Back-to-back 0xA3 then 0x0F with in_valid held high throughout.
    run_frame(8'hA3, 1'b0, 1000, 8'h0F);
    check_rx();
    t1 = last_start;
    check_idle_next();
    run_frame(8'h0F, 1'b0, 0, 8'h00);
    check_rx();
    check("b2b_start_gap", last_start - t1, FRAME + 1);
    check_idle_next();

    // Reset during data bit 3 of 0xFF abandons the frame.
    in_data  = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      if (k > 1) tick();
      check("pre_rst_tx", tx, exp_line(8'hFF, k));
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    repeat (110) tick();
    check("post_rst_tx", tx, 1);
    rx_q.delete();
    rx_start_q.delete();
    exp_q.delete();
    run_frame(8'h01, 1'b0, 0, 8'hAA);
    check_rx();
    check_idle_next();

    // Valid dropped a cycle after accept, data changed: held byte still sent.
    run_frame(8'h3C, 1'b0, 1, 8'h00);
    check_rx();
    check_idle_next();

    // Last byte: newline frame appended only when the feature is built in.
    run_frame(8'h41, 1'b1, 0, 8'h00);
    check_rx();
    check_idle_next();

    // Random bytes, random last flags and valid hold lengths.
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom);
      rl = 1'($urandom_range(0, 1));
      run_frame(rb, rl, $urandom_range(0, 3), 8'($urandom));
      check_rx();
      check_idle_next();
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
